// File: rtl/spi_peripheral.sv
// SPI target endpoint. It oversamples sclk/cs_n/copi in the clk domain and
// exchanges whole MSB-first frames with the core through a load/valid interface.
//
// state  | meaning
// IDLE   | deselected; the core may load the TX shifter
// ACTIVE | frame in progress; copi is sampled and poci is shifted
// DONE   | cs_n has been released; the received frame is published
module spi_peripheral #(
    parameter int DATA_WIDTH  = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          sync_rst_n,
    input  logic [1:0]                    spi_mode,
    input  logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_load,
    output logic                          tx_ready,
    input  logic                          sclk,
    input  logic                          cs_n,
    input  logic                          copi,
    output logic                          poci,
    output logic                          poci_oe,
    output logic [DATA_WIDTH-1:0]         rx_data,
    output logic [$clog2(DATA_WIDTH/8):0] rx_bytes,
    output logic                          rx_valid,
    output logic                          rx_partial
);

    localparam int CNT_W   = $clog2(DATA_WIDTH) + 1;
    localparam int BYTES_W = $clog2(DATA_WIDTH/8) + 1;
    localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_n_sync_q, cs_n_sync_d;
    logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
    logic                   sclk_dly_q, sclk_dly_d;
    logic                   cs_n_dly_q, cs_n_dly_d;
    logic [FLUSH_W-1:0]     flush_cnt_q, flush_cnt_d;
    logic                   cs_armed_q, cs_armed_d;

    logic [1:0]             mode_q, mode_d;
    logic                   first_lead_q, first_lead_d;
    logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;

    logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
    logic [BYTES_W-1:0]     rx_bytes_q, rx_bytes_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   rx_partial_q, rx_partial_d;

    logic sclk_s, cs_n_s, copi_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic lead_edge, trail_edge, sample_en, shift_en, frame_start;

    // Synchronizers and edge detection
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_n_sync_d = {cs_n_sync_q[SYNC_STAGES-2:0], cs_n};
        copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        cs_n_s      = cs_n_sync_q[SYNC_STAGES-1];
        copi_s      = copi_sync_q[SYNC_STAGES-1];
        sclk_dly_d  = sclk_s;
        cs_n_dly_d  = cs_n_s;
        sclk_rise   = sclk_s & ~sclk_dly_q;
        sclk_fall   = ~sclk_s & sclk_dly_q;
        cs_rise     = cs_n_s & ~cs_n_dly_q;
        cs_fall     = cs_armed_q & ~cs_n_s & cs_n_dly_q;
    end

    // The cs_n chain resets high, so a pin already low at reset release would
    // look like a falling edge. Only arm frame detection once the flushed chain
    // has shown cs_n genuinely high.
    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (flush_cnt_q != '0) begin
            flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
        end
        cs_armed_d = cs_armed_q | ((flush_cnt_q == '0) & cs_n_s);
    end

    always_comb begin
        lead_edge   = mode_q[0] ? sclk_fall : sclk_rise;
        trail_edge  = mode_q[0] ? sclk_rise : sclk_fall;
        frame_start = (state_q == ST_IDLE) & cs_fall;
        sample_en   = (state_q == ST_ACTIVE) & (mode_q[1] ? trail_edge : lead_edge);
        shift_en    = (state_q == ST_ACTIVE) &
                      (mode_q[1] ? (lead_edge & ~first_lead_q) : trail_edge);
    end

    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (cs_fall) state_d = ST_ACTIVE;
            ST_ACTIVE: if (cs_rise) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_ready = (state_q == ST_IDLE);
        poci_oe  = (state_q == ST_ACTIVE);
        poci     = tx_shift_q[DATA_WIDTH-1];
    end

    // Frame datapath
    always_comb begin
        mode_d       = mode_q;
        first_lead_d = first_lead_q;
        tx_shift_d   = tx_shift_q;
        rx_shift_d   = rx_shift_q;
        bit_cnt_d    = bit_cnt_q;

        if ((state_q == ST_IDLE) && tx_load) begin
            tx_shift_d = tx_data;
        end else if (shift_en) begin
            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
        end

        if (frame_start) begin
            mode_d       = spi_mode;
            first_lead_d = 1'b1;
            rx_shift_d   = '0;
            bit_cnt_d    = '0;
        end else begin
            if ((state_q == ST_ACTIVE) && lead_edge) begin
                first_lead_d = 1'b0;
            end
            if (sample_en) begin
                rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], copi_s};
                if (bit_cnt_q != CNT_W'(DATA_WIDTH)) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        rx_data_d    = rx_data_q;
        rx_bytes_d   = rx_bytes_q;
        rx_partial_d = rx_partial_q;
        rx_valid_d   = (state_q == ST_DONE);
        if (state_q == ST_DONE) begin
            rx_data_d    = rx_shift_q;
            rx_bytes_d   = BYTES_W'(bit_cnt_q >> 3);
            rx_partial_d = |bit_cnt_q[2:0];
        end
    end

    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            sclk_sync_q  <= '1;
            cs_n_sync_q  <= '1;
            copi_sync_q  <= '0;
            sclk_dly_q   <= 1'b1;
            cs_n_dly_q   <= 1'b1;
            flush_cnt_q  <= FLUSH_W'(SYNC_STAGES);
            cs_armed_q   <= 1'b0;
            mode_q       <= 2'b00;
            first_lead_q <= 1'b0;
            tx_shift_q   <= '0;
            rx_shift_q   <= '0;
            bit_cnt_q    <= '0;
            rx_data_q    <= '0;
            rx_bytes_q   <= '0;
            rx_valid_q   <= 1'b0;
            rx_partial_q <= 1'b0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            cs_n_sync_q  <= cs_n_sync_d;
            copi_sync_q  <= copi_sync_d;
            sclk_dly_q   <= sclk_dly_d;
            cs_n_dly_q   <= cs_n_dly_d;
            flush_cnt_q  <= flush_cnt_d;
            cs_armed_q   <= cs_armed_d;
            mode_q       <= mode_d;
            first_lead_q <= first_lead_d;
            tx_shift_q   <= tx_shift_d;
            rx_shift_q   <= rx_shift_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_data_q    <= rx_data_d;
            rx_bytes_q   <= rx_bytes_d;
            rx_valid_q   <= rx_valid_d;
            rx_partial_q <= rx_partial_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_bytes   = rx_bytes_q;
    assign rx_valid   = rx_valid_q;
    assign rx_partial = rx_partial_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: a behavioural SPI controller drives frames
// in all four modes and every result is compared against hand-computed values.
module tb_spi_peripheral;

    localparam int DW   = 64;
    localparam int HALF = 5;

    logic          clk = 1'b0;
    logic          sync_rst_n;
    logic [1:0]    spi_mode;
    logic [DW-1:0] tx_data;
    logic          tx_load;
    logic          tx_ready;
    logic          sclk;
    logic          cs_n;
    logic          copi;
    logic          poci;
    logic          poci_oe;
    logic [DW-1:0] rx_data;
    logic [3:0]    rx_bytes;
    logic          rx_valid;
    logic          rx_partial;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    spi_peripheral #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .sync_rst_n (sync_rst_n),
        .spi_mode   (spi_mode),
        .tx_data    (tx_data),
        .tx_load    (tx_load),
        .tx_ready   (tx_ready),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .copi       (copi),
        .poci       (poci),
        .poci_oe    (poci_oe),
        .rx_data    (rx_data),
        .rx_bytes   (rx_bytes),
        .rx_valid   (rx_valid),
        .rx_partial (rx_partial)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_valid === 1'b1) pulses++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [DW-1:0] v);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " poci"},       128'(poci),       128'(0));
        chk({tag, " poci_oe"},    128'(poci_oe),    128'(0));
        chk({tag, " tx_ready"},   128'(tx_ready),   128'(1));
        chk({tag, " rx_data"},    128'(rx_data),    128'(0));
        chk({tag, " rx_bytes"},   128'(rx_bytes),   128'(0));
        chk({tag, " rx_valid"},   128'(rx_valid),   128'(0));
        chk({tag, " rx_partial"}, 128'(rx_partial), 128'(0));
    endtask

    // Controller side of one frame; load_at >= 0 injects a tx_load at that bit.
    task automatic spi_frame(input logic [1:0] mode, input int nbits, input logic [127:0] mosi,
                             input int load_at, output logic [127:0] miso);
        logic cpol;
        logic cpha;
        cpol = mode[0];
        cpha = mode[1];
        miso = '0;
        spi_mode = mode;
        @(negedge clk);
        sclk = cpol;
        repeat (6) @(negedge clk);
        cs_n = 1'b0;
        repeat (HALF + 1) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            if (load_at == nbits - 1 - i) begin
                tx_data = '1;
                tx_load = 1'b1;
                spi_mode = ~mode;
                @(negedge clk);
                chk("busy tx_ready", 128'(tx_ready), 128'(0));
                chk("busy poci_oe", 128'(poci_oe), 128'(1));
                tx_load = 1'b0;
            end
            if (!cpha) begin
                copi = mosi[i];
                repeat (HALF) @(negedge clk);
                miso = {miso[126:0], poci};
                sclk = ~cpol;
                repeat (HALF) @(negedge clk);
                sclk = cpol;
            end else begin
                repeat (HALF) @(negedge clk);
                sclk = ~cpol;
                copi = mosi[i];
                repeat (HALF) @(negedge clk);
                miso = {miso[126:0], poci};
                sclk = cpol;
            end
        end
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        logic [127:0] miso;
        int           p0;

        sync_rst_n = 1'b0;
        spi_mode   = 2'b00;
        tx_data    = '0;
        tx_load    = 1'b0;
        sclk       = 1'b0;
        cs_n       = 1'b1;
        copi       = 1'b0;
        repeat (3) @(negedge clk);
        sync_rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk_reset_outputs("reset");

        // Mode 0, single byte
        load(64'hA500_0000_0000_0000);
        p0 = pulses;
        spi_frame(2'd0, 8, 128'h3C, -1, miso);
        chk("m0 byte poci", 128'(miso[7:0]), 128'hA5);
        chk("m0 byte rx_data", 128'(rx_data), 128'h3C);
        chk("m0 byte rx_bytes", 128'(rx_bytes), 128'(1));
        chk("m0 byte rx_partial", 128'(rx_partial), 128'(0));
        chk("m0 byte pulses", 128'(pulses - p0), 128'(1));

        // Full 64-bit frames in all four modes
        for (int m = 0; m < 4; m++) begin
            logic [1:0] md;
            md = 2'(m);
            load(64'h0123_4567_89AB_CDEF);
            p0 = pulses;
            spi_frame(md, 64, 128'h0123_4567_89AB_CDEF, -1, miso);
            chk("full poci", 128'(miso[63:0]), 128'h0123_4567_89AB_CDEF);
            chk("full rx_data", 128'(rx_data), 128'h0123_4567_89AB_CDEF);
            chk("full rx_bytes", 128'(rx_bytes), 128'(8));
            chk("full rx_partial", 128'(rx_partial), 128'(0));
            chk("full pulses", 128'(pulses - p0), 128'(1));
        end

        // 12-bit partial frame, CPOL=1 CPHA=0
        load(64'hF0F0_0000_0000_0000);
        spi_frame(2'd1, 12, 128'hABC, -1, miso);
        chk("partial poci", 128'(miso[11:0]), 128'hF0F);
        chk("partial rx_data", 128'(rx_data), 128'hABC);
        chk("partial rx_bytes", 128'(rx_bytes), 128'(1));
        chk("partial rx_partial", 128'(rx_partial), 128'(1));

        // 72-bit overflow frame
        load(64'hFEDC_BA98_7654_3210);
        spi_frame(2'd0, 72, 128'hFE_0123_4567_89AB_CDEF, -1, miso);
        chk("ovf poci", 128'(miso[71:0]), 128'hFE_DCBA_9876_5432_1000);
        chk("ovf rx_data", 128'(rx_data), 128'h0123_4567_89AB_CDEF);
        chk("ovf rx_bytes", 128'(rx_bytes), 128'(8));
        chk("ovf rx_partial", 128'(rx_partial), 128'(0));

        // tx_load and mode change while selected are ignored
        load(64'h1234_5678_9ABC_DEF0);
        spi_frame(2'd0, 16, 128'h0F0F, 4, miso);
        chk("busy poci data", 128'(miso[15:0]), 128'h1234);
        chk("busy rx_data", 128'(rx_data), 128'h0F0F);
        chk("busy rx_bytes", 128'(rx_bytes), 128'(2));
        chk("busy tx_ready after", 128'(tx_ready), 128'(1));
        spi_mode = 2'b00;

        // Reset in the middle of a frame
        load(64'hC300_0000_0000_0000);
        sclk = 1'b0;
        repeat (6) @(negedge clk);
        cs_n = 1'b0;
        repeat (HALF + 1) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            copi = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        sync_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("midreset");
        sync_rst_n = 1'b1;
        p0 = pulses;
        for (int i = 0; i < 5; i++) begin
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
            chk("midreset poci_oe", 128'(poci_oe), 128'(0));
        end
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("midreset pulses", 128'(pulses - p0), 128'(0));
        chk("midreset rx_data", 128'(rx_data), 128'(0));
        chk("midreset rx_bytes", 128'(rx_bytes), 128'(0));

        load(64'h5A00_0000_0000_0000);
        p0 = pulses;
        spi_frame(2'd0, 8, 128'h96, -1, miso);
        chk("after reset poci", 128'(miso[7:0]), 128'h5A);
        chk("after reset rx_data", 128'(rx_data), 128'h96);
        chk("after reset rx_bytes", 128'(rx_bytes), 128'(1));
        chk("after reset pulses", 128'(pulses - p0), 128'(1));

        // Empty frame
        p0 = pulses;
        cs_n = 1'b0;
        repeat (10) @(negedge clk);
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("empty pulses", 128'(pulses - p0), 128'(1));
        chk("empty rx_data", 128'(rx_data), 128'(0));
        chk("empty rx_bytes", 128'(rx_bytes), 128'(0));
        chk("empty rx_partial", 128'(rx_partial), 128'(0));

        // sclk toggling while deselected
        p0 = pulses;
        for (int i = 0; i < 6; i++) begin
            sclk = ~sclk;
            copi = ~copi;
            repeat (4) @(negedge clk);
            chk("idle sclk poci_oe", 128'(poci_oe), 128'(0));
        end
        repeat (6) @(negedge clk);
        chk("idle sclk pulses", 128'(pulses - p0), 128'(0));
        chk("idle sclk tx_ready", 128'(tx_ready), 128'(1));
        chk("idle sclk rx_bytes", 128'(rx_bytes), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
